// File: rtl/vstu_axi_write_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vstu_axi_write_responder_pkg
// Purpose  : AXI channel payload types, burst/response encodings and FSM state
//            type shared by the vector-store write responder slice.
// Revision : 1.0 - initial release
// ============================================================================
package vstu_axi_write_responder_pkg;

  localparam int c_AXI_DATA_WIDTH = 128;
  localparam int c_AXI_ADDR_WIDTH = 32;
  localparam int c_AXI_ID_WIDTH   = 4;

  // AXI4 burst type encodings
  localparam logic [1:0] c_BURST_FIXED = 2'b00;
  localparam logic [1:0] c_BURST_INCR  = 2'b01;
  localparam logic [1:0] c_BURST_WRAP  = 2'b10;

  // AXI4 response encodings
  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [c_AXI_ID_WIDTH-1:0]   id;
    logic [c_AXI_ADDR_WIDTH-1:0] addr;
    logic [7:0]                  len;
    logic [2:0]                  size;
    logic [1:0]                  burst;
  } ara_axi_aw_chan_t;

  typedef struct packed {
    logic [c_AXI_DATA_WIDTH-1:0]   data;
    logic [c_AXI_DATA_WIDTH/8-1:0] strb;
    logic                          last;
  } ara_axi_w_chan_t;

  typedef struct packed {
    logic [c_AXI_ID_WIDTH-1:0] id;
    logic [1:0]                resp;
  } ara_axi_b_chan_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/vstu_axi_write_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : vstu_axi_write_responder_if
// Purpose  : AW/W/B write-channel bundle between the store unit (master) and
//            the write responder (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface vstu_axi_write_responder_if;
  import vstu_axi_write_responder_pkg::*;

  ara_axi_aw_chan_t aw;
  logic             aw_valid;
  logic             aw_ready;
  ara_axi_w_chan_t  w;
  logic             w_valid;
  logic             w_ready;
  ara_axi_b_chan_t  b;
  logic             b_valid;
  logic             b_ready;

  modport master (
    output aw, aw_valid, w, w_valid, b_ready,
    input  aw_ready, w_ready, b, b_valid
  );

  modport slave (
    input  aw, aw_valid, w, w_valid, b_ready,
    output aw_ready, w_ready, b, b_valid
  );

endinterface
`default_nettype wire

// File: rtl/vstu_axi_write_responder_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vstu_axi_write_responder_fifo
// Purpose  : Small registered-output FIFO (no fall-through) used for the AW
//            request and B response buffers.
// Revision : 1.0 - initial release
// ============================================================================
module vstu_axi_write_responder_fifo #(
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = 8
) (
  input  wire logic                  clk_i,
  input  wire logic                  rst_i,
  input  wire logic                  push_i,
  input  wire logic [DATA_WIDTH-1:0] data_i,
  input  wire logic                  pop_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic      [DATA_WIDTH-1:0] data_o
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_PTR_W-1:0] c_LAST_PTR  = c_PTR_W'(DEPTH - 1);
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_CNT_W-1:0]    r_cnt;
  logic                  w_push;
  logic                  w_pop;

  function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] p);
    return (p == c_LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (r_cnt == c_DEPTH_CNT);
  assign empty_o = (r_cnt == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign data_o  = r_mem[r_rd_ptr];

  // Storage and pointers; entries are cleared so the head reads zero after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/vstu_axi_write_responder.sv
`default_nettype none
// ============================================================================
// Module   : vstu_axi_write_responder
// Purpose  : AXI4 write subordinate that commits vector-store bursts into a
//            single-port SRAM word port and returns one B per burst.
// Revision : 1.0 - initial release
// ============================================================================
module vstu_axi_write_responder
  import vstu_axi_write_responder_pkg::*;
#(
  parameter int                          AXI_DATA_WIDTH = c_AXI_DATA_WIDTH,
  parameter int                          AXI_ADDR_WIDTH = c_AXI_ADDR_WIDTH,
  parameter int                          MEM_ADDR_WIDTH = 14,
  parameter logic [AXI_ADDR_WIDTH-1:0]   MEM_BASE_ADDR  = 32'h8000_0000,
  parameter int                          AW_FIFO_DEPTH  = 2,
  parameter int                          B_FIFO_DEPTH   = 2
) (
  input  wire logic                        clk_i,
  input  wire logic                        rst_i,
  vstu_axi_write_responder_if.slave        axi,
  output logic                             mem_req_o,
  output logic [MEM_ADDR_WIDTH-1:0]        mem_addr_o,
  output logic [AXI_DATA_WIDTH-1:0]        mem_wdata_o,
  output logic [AXI_DATA_WIDTH/8-1:0]      mem_be_o,
  output logic                             busy_o
);

  localparam int c_OFFS_W = $clog2(AXI_DATA_WIDTH / 8);
  localparam int c_AW_W   = $bits(ara_axi_aw_chan_t);
  localparam int c_B_W    = $bits(ara_axi_b_chan_t);

  // Window bounds carry one extra bit so a window touching the top of the
  // address space cannot overflow.
  localparam logic [AXI_ADDR_WIDTH:0] c_WIN_LO   = {1'b0, MEM_BASE_ADDR};
  localparam logic [AXI_ADDR_WIDTH:0] c_WIN_SIZE =
    (AXI_ADDR_WIDTH + 1)'(1) << (MEM_ADDR_WIDTH + c_OFFS_W);
  localparam logic [AXI_ADDR_WIDTH:0] c_WIN_HI   = c_WIN_LO + c_WIN_SIZE;
  localparam logic [AXI_ADDR_WIDTH-1:0] c_ONE    = AXI_ADDR_WIDTH'(1);

  function automatic logic in_window(input logic [AXI_ADDR_WIDTH-1:0] a);
    logic [AXI_ADDR_WIDTH:0] ext;
    ext = {1'b0, a};
    return (ext >= c_WIN_LO) && (ext < c_WIN_HI);
  endfunction

  // FSM
  state_e r_state;
  state_e w_state_next;

  // Burst context
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [7:0]                r_len;
  logic [2:0]                r_size;
  logic [1:0]                r_burst;
  logic [c_AXI_ID_WIDTH-1:0] r_id;
  logic [7:0]                r_beat_cnt;
  logic                      r_err;

  // FIFO plumbing
  logic             w_aw_full;
  logic             w_aw_empty;
  logic             w_aw_pop;
  logic [c_AW_W-1:0] w_aw_head_bits;
  ara_axi_aw_chan_t w_aw_head;
  logic             w_b_full;
  logic             w_b_empty;
  logic             w_b_push;
  logic             w_b_pop;
  ara_axi_b_chan_t  w_b_in;
  logic [c_B_W-1:0] w_b_out_bits;

  // Beat datapath
  logic                      w_w_ready;
  logic                      w_w_hs;
  logic                      w_last_beat;
  logic                      w_beat_in_win;
  logic                      w_err_next;
  logic                      w_start_err;
  logic                      w_mem_req;
  logic [AXI_ADDR_WIDTH-1:0] w_step;
  logic [AXI_ADDR_WIDTH-1:0] w_addr_incr;
  logic [AXI_ADDR_WIDTH-1:0] w_mem_off;

  // ---------------------------------------------------------------------------
  // AW request buffer: accepts independently of the W phase.
  // ---------------------------------------------------------------------------
  vstu_axi_write_responder_fifo #(
    .DEPTH      (AW_FIFO_DEPTH),
    .DATA_WIDTH (c_AW_W)
  ) u_aw_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (axi.aw_valid && !w_aw_full && !rst_i),
    .data_i  (axi.aw),
    .pop_i   (w_aw_pop),
    .full_o  (w_aw_full),
    .empty_o (w_aw_empty),
    .data_o  (w_aw_head_bits)
  );

  assign w_aw_head    = w_aw_head_bits;
  // No request is advertised while reset is held so every output reads zero.
  assign axi.aw_ready = !w_aw_full && !rst_i;

  // ---------------------------------------------------------------------------
  // B response buffer: a slot is reserved on burst entry, so it never overflows.
  // ---------------------------------------------------------------------------
  vstu_axi_write_responder_fifo #(
    .DEPTH      (B_FIFO_DEPTH),
    .DATA_WIDTH (c_B_W)
  ) u_b_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_b_push),
    .data_i  (w_b_in),
    .pop_i   (w_b_pop),
    .full_o  (w_b_full),
    .empty_o (w_b_empty),
    .data_o  (w_b_out_bits)
  );

  assign axi.b_valid = !w_b_empty;
  assign axi.b       = w_b_out_bits;
  assign w_b_pop     = !w_b_empty && axi.b_ready;

  // ---------------------------------------------------------------------------
  // Beat-level combinational datapath
  // ---------------------------------------------------------------------------
  assign w_w_hs        = w_w_ready && axi.w_valid;
  assign w_last_beat   = (r_beat_cnt == r_len);
  assign w_beat_in_win = in_window(r_addr);
  // Error accumulated through the current beat: out-of-window or misplaced last.
  assign w_err_next    = r_err || !w_beat_in_win || (axi.w.last != w_last_beat);
  assign w_start_err   = (w_aw_head.burst == c_BURST_WRAP) || !in_window(w_aw_head.addr);

  // INCR aligns the first beat down to the beat size, then steps by it.
  assign w_step        = c_ONE << r_size;
  assign w_addr_incr   = (r_addr & ~(w_step - c_ONE)) + w_step;
  assign w_mem_off     = r_addr - MEM_BASE_ADDR;

  assign w_mem_req     = w_w_hs && !r_err && w_beat_in_win && (|axi.w.strb);
  assign mem_req_o     = w_mem_req;
  assign mem_addr_o    = w_mem_req ? w_mem_off[c_OFFS_W +: MEM_ADDR_WIDTH] : '0;
  assign mem_wdata_o   = w_mem_req ? axi.w.data : '0;
  assign mem_be_o      = w_mem_req ? axi.w.strb : '0;

  assign w_b_in.id     = r_id;
  assign w_b_in.resp   = w_err_next ? c_RESP_SLVERR : c_RESP_OKAY;

  assign axi.w_ready   = w_w_ready;
  assign busy_o        = (r_state == ST_BURST) || !w_aw_empty || !w_b_empty;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: start a burst only when a B slot is free.
  always_comb begin
    w_state_next = r_state;
    w_w_ready    = 1'b0;
    w_aw_pop     = 1'b0;
    w_b_push     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_aw_empty && !w_b_full) begin
          w_aw_pop     = 1'b1;
          w_state_next = ST_BURST;
        end
      end
      ST_BURST: begin
        w_w_ready = 1'b1;
        if (axi.w_valid && w_last_beat) begin
          w_b_push     = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Burst context: latched on entry, advanced on each accepted beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr     <= '0;
      r_len      <= '0;
      r_size     <= '0;
      r_burst    <= '0;
      r_id       <= '0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else if (w_aw_pop) begin
      r_addr     <= w_aw_head.addr;
      r_len      <= w_aw_head.len;
      r_size     <= w_aw_head.size;
      r_burst    <= w_aw_head.burst;
      r_id       <= w_aw_head.id;
      r_beat_cnt <= '0;
      r_err      <= w_start_err;
    end else if (w_w_hs) begin
      r_err <= w_err_next;
      if (!w_last_beat) begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
      end
      if (r_burst == c_BURST_INCR) begin
        r_addr <= w_addr_incr;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/vstu_axi_write_responder.md
Name: vstu_axi_write_responder

Overview:
- AXI4 write-channel responder (subordinate) that receives the vector store unit's AW/W traffic and commits it into an on-FPGA SRAM word port, returning one B response per burst.
- Sits between the store path of the Marian FPGA top and a single-port block RAM.
- Gives bare-metal FPGA builds a store target, and gives store-unit verification a self-checking memory endpoint.

Parameters:
- AxiDataWidth, 128, W data width in bits; a power of two, at least 32.
- AxiAddrWidth, 32, AW address width in bits.
- MemAddrWidth, 14, SRAM word-address width; one word is AxiDataWidth bits.
- MemBaseAddr, 32'h8000_0000, byte base address of the SRAM window.
- AwFifoDepth, 2, AW request buffer depth; at least 1.
- BFifoDepth, 2, B response buffer depth; at least 1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- axi_aw_i  in  ara_axi_aw_chan_t  AW payload: id, addr, len, size, burst
- axi_aw_valid_i  in  1  AW valid
- axi_aw_ready_o  out  1  AW ready
- axi_w_i  in  ara_axi_w_chan_t  W payload: data, strb, last
- axi_w_valid_i  in  1  W valid
- axi_w_ready_o  out  1  W ready
- axi_b_o  out  ara_axi_b_chan_t  B payload: id, resp
- axi_b_valid_o  out  1  B valid
- axi_b_ready_i  in  1  B ready
- mem_req_o  out  1  SRAM write strobe
- mem_addr_o  out  MemAddrWidth  SRAM word address
- mem_wdata_o  out  AxiDataWidth  SRAM write data
- mem_be_o  out  AxiDataWidth/8  SRAM byte enables
- busy_o  out  1  a burst is in progress or any FIFO is non-empty

Behaviour:
- Reset: all outputs are 0, both FIFOs are empty, FSM is IDLE, all counters are 0.
- Reset asserted mid-burst discards the burst; no B is issued for it.
- AW handling: axi_aw_ready_o = !aw_fifo_full. The full payload is pushed on handshake. AW acceptance is independent of the W phase.
- FSM states: IDLE, BURST.
- IDLE -> BURST when the AW FIFO is non-empty and the B FIFO is not full. The FSM pops the AW entry and latches into registers: addr_q = addr, len_q, size_q, burst_q, id_q. It also sets beat_cnt = 0 and err_q = 0.
- IDLE sets err_q = 1 if burst == WRAP or if addr is outside [MemBaseAddr, MemBaseAddr + 2^MemAddrWidth * AxiDataWidth/8).
- BURST: axi_w_ready_o = 1, combinational. axi_w_ready_o is 0 in IDLE.
- On a W handshake in BURST, mem_req_o = !err_q && |strb, in the same cycle as the handshake (zero latency; the SRAM write lands at the next edge).
  - mem_addr_o = (addr_q - MemBaseAddr) >> log2(AxiDataWidth/8), truncated to MemAddrWidth bits.
  - mem_wdata_o = w.data; mem_be_o = w.strb, passed through unmasked. The initiator supplies lane-correct strobes.
- Per-beat address update for INCR: addr_q = (addr_q & ~((1<<size_q)-1)) + (1<<size_q), i.e. the first beat is aligned down, then increments by the beat size.
- Per-beat address update for FIXED: addr_q is held.
- Range check: beats that cross the window end set err_q and suppress mem_req_o for that beat and for every following beat of the burst.
- Burst end occurs on the beat where beat_cnt == len_q. If w.last != (beat_cnt == len_q) on any beat, err_q is set.
- At burst end, the FSM pushes {id_q, err_q ? SLVERR : OKAY} into the B FIFO and returns to IDLE. There is one idle cycle between bursts.
- A W beat with last = 1 arriving before beat_cnt == len_q does not end the burst; it only flags an error.
- B channel: axi_b_valid_o = !b_fifo_empty; the FIFO pops on valid && ready.
  - The earliest B is the cycle after the last-W handshake.
  - B order equals AW order, and IDs pass through.
- Simultaneous B push and pop on a full FIFO cannot occur, because entry to BURST reserves a B slot.
- beat_cnt is 8 bits and never wraps, since it is bounded by len_q.
- busy_o = (state == BURST) || !aw_fifo_empty || !b_fifo_empty.

Decomposition:
- ara_axi_aw_chan_t, and the axi_pkg RESP_OKAY/RESP_SLVERR and BURST_* constants, come from marian_fpga_pkg / axi_pkg. No new package content is required beyond exporting ara_axi_aw_chan_t.
- AW and B buffers are instances of the common_cells fifo_v3 (FALL_THROUGH = 0).
- The address/range computation stays inline; no further sub-module.

Test Plan:
- Single beat, AW{id=3, addr=MemBaseAddr+0x20, len=0, size=4, INCR}, strb=16'hFFFF -> mem_req at word 2 with full mask. B{id=3, OKAY} appears one cycle after the W handshake.
- INCR burst, len=3, size=4, start at +0x0 -> mem addresses 0,1,2,3. last is seen only on the 4th beat. One B OKAY.
- Unaligned narrow burst, addr=+0x6, size=2, len=2 -> word 0 three times. The address sequence is 0x6, 0x8, 0xC. The bench's strobes appear unmodified on mem_be_o.
- Error cases:
  - WRAP burst, or addr = MemBaseAddr - 16 -> no mem_req; B resp = SLVERR.
  - last asserted on beat 1 of a len=2 burst -> 3 beats consumed, then SLVERR.
- Backpressure, BFifoDepth=2, axi_b_ready_i=0, 3 back-to-back single-beat AWs -> 2 bursts complete, and axi_w_ready_o stays 0 for the third. Raising b_ready drains B in id order and the third burst then completes.
- Reset mid-burst (after beat 1 of len=3) -> all outputs 0 next cycle; no B issued; a fresh burst after release completes with OKAY.
